timer_alarm: RTL and testbench

Compare/alarm stage that consumes the free-running 64-bit count produced by the timer core and raises an interrupt when the count reaches a programmed value. It supports one-shot and periodic alarms, with automatic reload of the compare value by a programmed period. It sits downstream of the timer counter, inside the timer peripheral. Its control inputs come from the software register file and its `irq` output goes to the system interrupt line.

---
 rtl/timer_alarm_if.sv | 30 +++
 rtl/timer_alarm.sv | 104 ++++++++++
 tb/tb_timer_alarm.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/timer_alarm_if.sv
// Signal bundle between the timer register file and the compare/alarm stage.
// The master side drives the count and the control strobes. The slave side returns the interrupt and the status.
interface timer_alarm_if #(
  parameter int DATA_W = 32
);
  logic [2*DATA_W-1:0] timer_value;
  logic                alarm_en;
  logic                periodic;
  logic                cmp_wr;
  logic [2*DATA_W-1:0] cmp_wdata;
  logic                period_wr;
  logic [2*DATA_W-1:0] period_wdata;
  logic                irq_ack;
  logic                irq;
  logic                armed;
  logic [2*DATA_W-1:0] cmp_value;
  logic [7:0]          miss_cnt;

  modport master (
    output timer_value, alarm_en, periodic, cmp_wr, cmp_wdata,
           period_wr, period_wdata, irq_ack,
    input  irq, armed, cmp_value, miss_cnt
  );

  modport slave (
    input  timer_value, alarm_en, periodic, cmp_wr, cmp_wdata,
           period_wr, period_wdata, irq_ack,
    output irq, armed, cmp_value, miss_cnt
  );
endinterface

// File: rtl/timer_alarm.sv
// Wrap-safe compare/alarm stage with one-shot and periodic modes, downstream of the 64-bit timer count.
// Define TIMER_ALARM_MISS_CNT_EN to build the saturating missed-alarm counter; otherwise miss_cnt reads 0.
module timer_alarm #(
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  timer_alarm_if.slave bus
);
  localparam int W = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   cmp_q, cmp_d;
  logic [W-1:0]   period_q, period_d;
  logic           pend_q, pend_d;
  logic [W-1:0]   diff;
  logic           hit;
  logic           fire;

  // The count is at or past cmp when the modular difference lies in the lower half of the range.
  assign diff = bus.timer_value - cmp_q;
  assign hit  = ~diff[W-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cmp_q    <= '0;
      period_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmp_q    <= cmp_d;
      period_q <= period_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cmp_d    = cmp_q;
    period_d = period_q;
    pend_d   = pend_q;
    fire     = 1'b0;

    if (bus.period_wr) period_d = bus.period_wdata;

    case (state_q)
      IDLE: begin
        if (bus.alarm_en) state_d = ARMED;
      end
      ARMED: begin
        if (hit) begin
          fire = 1'b1;
          if (!bus.periodic || (period_q == '0)) state_d = DONE;
          else cmp_d = cmp_q + period_q;
        end
      end
      DONE: begin
        if (bus.cmp_wr) state_d = ARMED;
      end
      default: state_d = IDLE;
    endcase

    // A software write overrides the periodic reload computed above.
    if (bus.cmp_wr) cmp_d = bus.cmp_wdata;

    if (fire) pend_d = 1'b1;
    else if (bus.irq_ack) pend_d = 1'b0;

    if (!bus.alarm_en) begin
      state_d = IDLE;
      pend_d  = 1'b0;
    end
  end

`ifdef TIMER_ALARM_MISS_CNT_EN
  logic [7:0] miss_q, miss_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) miss_q <= '0;
    else      miss_q <= miss_d;
  end

  always_comb begin
    miss_d = miss_q;
    if (fire && pend_q && !bus.irq_ack && (miss_q != '1)) miss_d = miss_q + 8'd1;
    if (!bus.alarm_en) miss_d = '0;
  end

  assign bus.miss_cnt = miss_q;
`else
  assign bus.miss_cnt = '0;
`endif

  assign bus.irq       = pend_q;
  assign bus.armed     = (state_q == ARMED);
  assign bus.cmp_value = cmp_q;
endmodule

// File: tb/tb_timer_alarm.sv
// Self-checking bench for timer_alarm: directed scenarios plus random stimulus, checked every cycle
// against a flag-based behavioural model of the alarm rules.
module tb_timer_alarm;
  localparam int DATA_W = 32;
  localparam int W      = 2 * DATA_W;
  localparam logic [W-1:0] HALF = 64'h8000_0000_0000_0000;
`ifdef TIMER_ALARM_MISS_CNT_EN
  localparam bit MISS_EN = 1'b1;
`else
  localparam bit MISS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  timer_alarm_if #(.DATA_W(DATA_W)) bus ();

  timer_alarm #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: armed / fired-one-shot flags, neither set means disarmed.
  bit           m_arm  = 1'b0;
  bit           m_done = 1'b0;
  bit           m_pend = 1'b0;
  logic [W-1:0] m_cmp  = '0;
  logic [W-1:0] m_per  = '0;
  int           m_miss = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit           idle_pre, done_pre, fire;
    logic [W-1:0] per_pre;
    if (!rst) begin
      m_arm = 1'b0; m_done = 1'b0; m_pend = 1'b0;
      m_cmp = '0; m_per = '0; m_miss = 0;
    end else begin
      idle_pre = !m_arm && !m_done;
      done_pre = m_done;
      per_pre  = m_per;
      fire     = m_arm && ((bus.timer_value - m_cmp) < HALF);
      if (bus.period_wr) m_per = bus.period_wdata;
      if (fire) begin
        if (m_pend && !bus.irq_ack) m_miss = (m_miss < 255) ? m_miss + 1 : 255;
        m_pend = 1'b1;
        if (bus.periodic && per_pre != '0) m_cmp = m_cmp + per_pre;
        else begin m_arm = 1'b0; m_done = 1'b1; end
      end else if (bus.irq_ack) begin
        m_pend = 1'b0;
      end
      if (idle_pre) m_arm = 1'b1;
      if (done_pre && bus.cmp_wr) begin m_done = 1'b0; m_arm = 1'b1; end
      if (bus.cmp_wr) m_cmp = bus.cmp_wdata;
      if (!bus.alarm_en) begin
        m_arm = 1'b0; m_done = 1'b0; m_pend = 1'b0; m_miss = 0;
      end
    end
    #1;
    if (chk_en) begin
      check("model_irq", {63'd0, bus.irq}, {63'd0, m_pend});
      check("model_armed", {63'd0, bus.armed}, {63'd0, m_arm});
      check("model_cmp", bus.cmp_value, m_cmp);
      check("model_miss", {56'd0, bus.miss_cnt}, MISS_EN ? W'(m_miss) : '0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.cmp_wr    = 1'b0;
    bus.period_wr = 1'b0;
    bus.irq_ack   = 1'b0;
  endtask

  initial begin
    logic [W-1:0] base;
    rst              = 1'b0;
    bus.timer_value  = '0;
    bus.alarm_en     = 1'b0;
    bus.periodic     = 1'b0;
    bus.cmp_wr       = 1'b0;
    bus.cmp_wdata    = '0;
    bus.period_wr    = 1'b0;
    bus.period_wdata = '0;
    bus.irq_ack      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_irq", {63'd0, bus.irq}, '0);
    check("reset_armed", {63'd0, bus.armed}, '0);
    check("reset_cmp", bus.cmp_value, '0);
    check("reset_miss", {56'd0, bus.miss_cnt}, '0);
    chk_en = 1'b1;
    rst    = 1'b1;

    // One-shot at 100
    bus.cmp_wdata = 64'd100; bus.cmp_wr = 1'b1; bus.periodic = 1'b0; bus.alarm_en = 1'b1;
    tick();
    check("oneshot_armed", {63'd0, bus.armed}, 64'd1);
    for (int t = 0; t <= 120; t++) begin
      bus.timer_value = W'(t);
      tick();
      if (t == 99) check("oneshot_before", {63'd0, bus.irq}, '0);
      if (t == 100) begin
        check("oneshot_fire", {63'd0, bus.irq}, 64'd1);
        check("oneshot_done", {63'd0, bus.armed}, '0);
      end
    end
    bus.irq_ack = 1'b1;
    tick();
    check("oneshot_ack", {63'd0, bus.irq}, '0);
    bus.timer_value = 64'd100;
    repeat (5) tick();
    check("oneshot_nofire", {63'd0, bus.irq}, '0);

    // Periodic 10 + n*20, no ack
    bus.alarm_en = 1'b0;
    tick();
    bus.alarm_en = 1'b1; bus.periodic = 1'b1; bus.timer_value = '0;
    bus.cmp_wdata = 64'd10; bus.cmp_wr = 1'b1;
    bus.period_wdata = 64'd20; bus.period_wr = 1'b1;
    tick();
    for (int t = 0; t <= 60; t++) begin
      bus.timer_value = W'(t);
      tick();
    end
    check("periodic_cmp", bus.cmp_value, 64'd70);
    check("periodic_miss", {56'd0, bus.miss_cnt}, MISS_EN ? 64'd2 : 64'd0);
    check("periodic_irq", {63'd0, bus.irq}, 64'd1);

    // Wrap through 2^64-1 -> 0
    bus.alarm_en = 1'b0;
    tick();
    base = 64'hFFFF_FFFF_FFFF_FFF8;
    bus.alarm_en = 1'b1; bus.timer_value = base;
    bus.cmp_wdata = 64'hFFFF_FFFF_FFFF_FFFB; bus.cmp_wr = 1'b1;
    bus.period_wdata = 64'd10; bus.period_wr = 1'b1;
    tick();
    for (int i = 0; i < 14; i++) begin
      bus.timer_value = base + W'(i);
      if (bus.irq) bus.irq_ack = 1'b1;
      tick();
      if (i == 3) begin
        check("wrap_fire1", {63'd0, bus.irq}, 64'd1);
        check("wrap_cmp1", bus.cmp_value, 64'd5);
      end else if (i == 13) begin
        check("wrap_fire2", {63'd0, bus.irq}, 64'd1);
        check("wrap_cmp2", bus.cmp_value, 64'd15);
      end else if (i > 3) begin
        check("wrap_quiet", {63'd0, bus.irq}, '0);
      end
    end

    // Fire + ack collision, then write in the reload cycle
    bus.timer_value = 64'd15; bus.irq_ack = 1'b1;
    tick();
    check("collide_irq", {63'd0, bus.irq}, 64'd1);
    check("collide_cmp", bus.cmp_value, 64'd25);
    check("collide_miss", {56'd0, bus.miss_cnt}, '0);
    bus.timer_value = 64'd25; bus.cmp_wdata = 64'd500; bus.cmp_wr = 1'b1;
    tick();
    check("wr_over_reload", bus.cmp_value, 64'd500);
    check("wr_reload_miss", {56'd0, bus.miss_cnt}, MISS_EN ? 64'd1 : 64'd0);

    // Disarm while pending
    bus.alarm_en = 1'b0;
    tick();
    check("disarm_irq", {63'd0, bus.irq}, '0);
    check("disarm_miss", {56'd0, bus.miss_cnt}, '0);
    check("disarm_armed", {63'd0, bus.armed}, '0);
    check("disarm_cmp", bus.cmp_value, 64'd500);

    // Asynchronous reset mid-operation
    bus.alarm_en = 1'b1; bus.periodic = 1'b0; bus.timer_value = 64'd600;
    tick();
    tick();
    check("pre_reset_irq", {63'd0, bus.irq}, 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_irq", {63'd0, bus.irq}, '0);
    check("async_armed", {63'd0, bus.armed}, '0);
    check("async_cmp", bus.cmp_value, '0);
    check("async_miss", {56'd0, bus.miss_cnt}, '0);
    bus.alarm_en = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Saturation: fire every cycle for 300 cycles
    bus.alarm_en = 1'b1; bus.periodic = 1'b1; bus.timer_value = '0;
    bus.cmp_wdata = '0; bus.cmp_wr = 1'b1;
    bus.period_wdata = 64'd1; bus.period_wr = 1'b1;
    tick();
    for (int i = 0; i < 300; i++) begin
      bus.timer_value = W'(i);
      tick();
    end
    check("sat_miss", {56'd0, bus.miss_cnt}, MISS_EN ? 64'd255 : 64'd0);
    check("sat_cmp", bus.cmp_value, 64'd300);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bus.timer_value = bus.timer_value + W'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) bus.timer_value = {$urandom, $urandom};
      bus.alarm_en = ($urandom_range(0, 40) != 0);
      if ($urandom_range(0, 63) == 0) bus.periodic = ~bus.periodic;
      if ($urandom_range(0, 15) == 0) begin
        bus.cmp_wr    = 1'b1;
        bus.cmp_wdata = bus.timer_value + W'($urandom_range(0, 60)) - 64'd10;
      end
      if ($urandom_range(0, 15) == 0) begin
        bus.period_wr    = 1'b1;
        bus.period_wdata = W'($urandom_range(0, 25));
      end
      bus.irq_ack = ($urandom_range(0, 5) == 0);
      tick();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
